// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with one-entry decode buffer
// Drives PC update controls, issues imem word requests, traps misalignment and timeouts.
module fetch_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] current_pc,
   output logic        pc_we,
   output logic        pc_src,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   output logic        fetch_fault
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       inst_pc_q, inst_pc_d;

   logic aligned;
   logic timeout;

   assign aligned = (current_pc[1:0] == 2'b00);
   assign timeout = (wait_q == WAIT_LAST);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            wait_d  = '0;
         end
         S_REQ: begin
            // A redirect abandons the request; returned data is dropped.
            if (redirect) begin
               state_d = S_REQ;
               wait_d  = '0;
            end else if (!aligned) begin
               state_d = S_FAULT;
            end else if (imem_ready) begin
               state_d   = S_HOLD;
               inst_d    = imem_rdata;
               inst_pc_d = current_pc;
            end else if (timeout) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect || inst_ready) begin
               state_d = S_REQ;
               wait_d  = '0;
            end
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
      if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
         inst_d    = '0;
         inst_pc_d = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   // Redirect overrides the sequential +4 advance in every live state.
   assign pc_we       = (state_q != S_FAULT) &&
                        (redirect || ((state_q == S_REQ) && aligned && imem_ready));
   assign pc_src      = (state_q != S_FAULT) && redirect;
   assign imem_req    = (state_q == S_REQ) && aligned;
   assign imem_addr   = (state_q == S_REQ) ? current_pc : 32'h0;
   assign inst_valid  = (state_q == S_HOLD);
   assign fetch_fault = (state_q == S_FAULT);
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed timing checks plus randomized scoreboard for fetch_ctrl
module tb_fetch_ctrl;

   localparam int unsigned MAX_WAIT = 8;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [31:0] current_pc;
   logic        pc_we;
   logic        pc_src;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect;
   logic        fetch_fault;
   logic [31:0] redirect_target;

   int          checks = 0;
   int          failures = 0;
   int          consumed = 0;
   bit          sb_on = 1'b0;
   logic [31:0] model_pc;
   logic [63:0] exp_q[$];
   logic [63:0] sb_e;

   fetch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .current_pc (current_pc),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .redirect   (redirect),
      .fetch_fault(fetch_fault)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hBAD0_0BAD;

   // PC register: +4 or the redirect target on the ALU input.
   always @(posedge sys_clk) begin
      if (sys_rst) current_pc <= 32'h0;
      else if (pc_we) current_pc <= pc_src ? redirect_target : current_pc + 32'd4;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_for_req(input logic [31:0] addr, input int budget);
      int n;
      n = 0;
      @(negedge sys_clk);
      while (!(imem_req && imem_addr == addr) && n < budget) begin
         cyc();
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL wait_req: no request at %h within %0d cycles", addr, budget);
      end
   endtask

   // Scoreboard monitor: compares every cycle against the transaction model.
   always @(negedge sys_clk) begin
      if (sb_on) begin
         chk1("sb_inst_valid", inst_valid, exp_q.size() != 0);
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_pop: handshake got inst_pc %h expected no instruction", inst_pc);
            end else begin
               sb_e = exp_q.pop_front();
               chk32("sb_inst_pc", inst_pc, sb_e[63:32]);
               chk32("sb_inst", inst, sb_e[31:0]);
               consumed++;
            end
         end
         chk1("sb_pc_we", pc_we, redirect | imem_ready);
         if (pc_we) chk1("sb_pc_src", pc_src, redirect);
         if (imem_req) chk32("sb_imem_addr", imem_addr, model_pc);
         chk1("sb_req_while_full", imem_req && (exp_q.size() != 0), 1'b0);
         chk1("sb_fault", fetch_fault, 1'b0);
      end
   end

   initial begin
      int mem_cnt;
      int mem_lat;
      bit drop;
      bit fetch;
      bit req;

      sys_rst = 1'b1;
      redirect = 1'b0;
      redirect_target = 32'h0;
      inst_ready = 1'b0;
      imem_ready = 1'b0;
      cyc();
      cyc();
      @(negedge sys_clk);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_fault", fetch_fault, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_pc_we", pc_we, 1'b0);
      chk1("rst_pc_src", pc_src, 1'b0);
      chk32("rst_inst", inst, 32'h0);
      chk32("rst_inst_pc", inst_pc, 32'h0);
      cyc();
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk1("idle_no_req", imem_req, 1'b0);
      imem_ready = 1'b1;
      inst_ready = 1'b1;
      cyc();

      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         chk1("seq_req", imem_req, 1'b1);
         chk32("seq_addr", imem_addr, 32'(4 * k));
         chk1("seq_pc_we", pc_we, 1'b1);
         chk1("seq_pc_src", pc_src, 1'b0);
         cyc();
         @(negedge sys_clk);
         chk1("seq_valid", inst_valid, 1'b1);
         chk32("seq_inst_pc", inst_pc, 32'(4 * k));
         chk32("seq_inst", inst, mem_word(32'(4 * k)));
         chk1("seq_hold_req", imem_req, 1'b0);
         chk1("seq_hold_pc_we", pc_we, 1'b0);
         chk32("seq_pc", current_pc, 32'(4 * k + 4));
         cyc();
      end

      imem_ready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         @(negedge sys_clk);
         chk1("wait_req", imem_req, 1'b1);
         chk32("wait_addr", imem_addr, 32'h10);
         chk1("wait_pc_we", pc_we, 1'b0);
         cyc();
      end
      imem_ready = 1'b1;
      @(negedge sys_clk);
      chk1("wait_req_last", imem_req, 1'b1);
      chk32("wait_addr_last", imem_addr, 32'h10);
      chk1("wait_pc_we_pulse", pc_we, 1'b1);
      cyc();
      inst_ready = 1'b0;
      for (int b = 0; b < 5; b++) begin
         @(negedge sys_clk);
         chk1("bp_valid", inst_valid, 1'b1);
         chk32("bp_inst_pc", inst_pc, 32'h10);
         chk32("bp_inst", inst, mem_word(32'h10));
         chk1("bp_req", imem_req, 1'b0);
         chk1("bp_pc_we", pc_we, 1'b0);
         cyc();
      end
      inst_ready = 1'b1;
      @(negedge sys_clk);
      chk1("bp_consume_valid", inst_valid, 1'b1);
      cyc();
      @(negedge sys_clk);
      chk1("bp_next_req", imem_req, 1'b1);
      chk32("bp_next_addr", imem_addr, 32'h14);

      wait_for_req(32'h20, 20);
      imem_ready = 1'b0;
      cyc();
      imem_ready = 1'b1;
      redirect = 1'b1;
      redirect_target = 32'h1000;
      @(negedge sys_clk);
      chk1("rd_pc_we", pc_we, 1'b1);
      chk1("rd_pc_src", pc_src, 1'b1);
      chk32("rd_old_addr", imem_addr, 32'h20);
      cyc();
      redirect = 1'b0;
      imem_ready = 1'b0;
      @(negedge sys_clk);
      chk1("rd_discard_valid", inst_valid, 1'b0);
      chk32("rd_discard_inst_pc", inst_pc, 32'h1C);
      chk32("rd_pc", current_pc, 32'h1000);
      chk1("rd_req", imem_req, 1'b1);
      chk32("rd_addr", imem_addr, 32'h1000);

      imem_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      imem_ready = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h2000;
      @(negedge sys_clk);
      chk1("hold_valid", inst_valid, 1'b1);
      chk32("hold_inst_pc", inst_pc, 32'h1000);
      chk1("hold_pc_we", pc_we, 1'b1);
      chk1("hold_pc_src", pc_src, 1'b1);
      cyc();
      redirect = 1'b0;
      @(negedge sys_clk);
      chk1("hold_drop_valid", inst_valid, 1'b0);
      chk1("hold_new_req", imem_req, 1'b1);
      chk32("hold_new_addr", imem_addr, 32'h2000);

      cyc();
      redirect = 1'b1;
      redirect_target = 32'h1002;
      @(negedge sys_clk);
      chk1("mis_redirect_we", pc_we, 1'b1);
      cyc();
      redirect = 1'b0;
      @(negedge sys_clk);
      chk1("mis_req", imem_req, 1'b0);
      chk1("mis_not_yet_fault", fetch_fault, 1'b0);
      chk32("mis_pc", current_pc, 32'h1002);
      cyc();
      @(negedge sys_clk);
      chk1("mis_fault", fetch_fault, 1'b1);
      chk1("mis_valid", inst_valid, 1'b0);
      chk32("mis_inst", inst, 32'h0);
      chk32("mis_inst_pc", inst_pc, 32'h0);
      cyc();
      redirect = 1'b1;
      redirect_target = 32'h3000;
      @(negedge sys_clk);
      chk1("flt_pc_we", pc_we, 1'b0);
      chk1("flt_pc_src", pc_src, 1'b0);
      chk1("flt_req", imem_req, 1'b0);
      cyc();
      redirect = 1'b0;
      @(negedge sys_clk);
      chk1("flt_sticky", fetch_fault, 1'b1);
      chk32("flt_pc_kept", current_pc, 32'h1002);

      cyc();
      sys_rst = 1'b1;
      cyc();
      cyc();
      @(negedge sys_clk);
      chk1("rst2_fault", fetch_fault, 1'b0);
      cyc();
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk1("rst2_idle_req", imem_req, 1'b0);
      cyc();
      @(negedge sys_clk);
      chk1("rst2_req", imem_req, 1'b1);
      chk32("rst2_addr", imem_addr, 32'h0);
      for (int i = 0; i < int'(MAX_WAIT); i++) begin
         chk1("to_no_fault", fetch_fault, 1'b0);
         chk1("to_pc_we", pc_we, 1'b0);
         chk1("to_req", imem_req, 1'b1);
         cyc();
         @(negedge sys_clk);
      end
      chk1("to_fault", fetch_fault, 1'b1);
      chk1("to_fault_pc_we", pc_we, 1'b0);

      cyc();
      sys_rst = 1'b1;
      inst_ready = 1'b0;
      cyc();
      cyc();
      sys_rst = 1'b0;
      model_pc = 32'h0;
      exp_q.delete();
      mem_cnt = 0;
      mem_lat = $urandom_range(0, 3);
      sb_on = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         redirect = ($urandom_range(0, 9) == 0);
         redirect_target = $urandom & 32'h0000_FFFC;
         inst_ready = ($urandom_range(0, 3) != 0);
         #1;
         imem_ready = imem_req && (mem_cnt >= mem_lat);
         req = imem_req;
         drop = redirect && !inst_ready && (exp_q.size() != 0);
         fetch = imem_ready && !redirect;
         @(posedge sys_clk);
         if (redirect) begin
            if (drop) void'(exp_q.pop_front());
            model_pc = redirect_target;
         end else if (fetch) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
         end
         if (redirect || imem_ready) begin
            mem_cnt = 0;
            mem_lat = $urandom_range(0, 3);
         end else if (req) begin
            mem_cnt++;
         end
         #1;
      end
      sb_on = 1'b0;
      checks++;
      if (consumed < 100) begin
         failures++;
         $display("FAIL sb_progress: consumed %0d expected at least 100", consumed);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the multi-cycle RV32 core. It drives the PC register's update controls (`pc_we`, `pc_src`), issues word requests to instruction memory at `current_pc`, and buffers one fetched instruction for decode behind a valid/ready handshake. Branch and jump redirects from execute take priority over sequential advance. Misaligned PCs and memory timeouts are trapped into a sticky fault state.

## Interface

Parameters:
- `MAX_WAIT`, default 255: number of consecutive `REQ` cycles without `imem_ready` before a timeout fault.

Ports:
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `current_pc`  in  32  PC register output.
- `pc_we`  out  1  PC update enable; PC loads its next value at the next edge.
- `pc_src`  out  1  PC next-value select: 0 = `current_pc+4`, 1 = ALU output (redirect target).
- `imem_req`  out  1  instruction memory read request.
- `imem_addr`  out  32  request address, equal to `current_pc`.
- `imem_ready`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready` is high.
- `inst_valid`  out  1  buffered instruction available to decode.
- `inst`  out  32  buffered instruction.
- `inst_pc`  out  32  address the buffered instruction was fetched from.
- `inst_ready`  in  1  decode accepts `inst` this cycle.
- `redirect`  in  1  execute requests a PC redirect; the target is on the PC block's ALU input this cycle.
- `fetch_fault`  out  1  sticky fault flag; cleared only by reset.

## Operation

States: `IDLE`, `REQ`, `HOLD`, `FAULT`.

- **Reset:** state is `IDLE`. All outputs are 0: `pc_we`, `pc_src`, `imem_req`, `inst_valid`, `inst`, `inst_pc`, `fetch_fault`. The wait counter is 0. Reset mid-request abandons the request with no PC write.
- **IDLE:** moves unconditionally to `REQ` next cycle. A redirect here produces `pc_we=1`, `pc_src=1`.
- **REQ:**
  - `imem_req` = (`current_pc[1:0]==0`) and `imem_addr=current_pc`, both combinational.
  - Misaligned PC: `imem_req` stays 0 and the next state is `FAULT`.
  - `imem_ready`: `inst` takes `imem_rdata` and `inst_pc` takes `current_pc` at the edge. Same cycle `pc_we=1`, `pc_src=0`. Next state is `HOLD`.
  - No ready: the wait counter increments. When the counter equals `MAX_WAIT-1` and ready is still low, the next state is `FAULT`.
  - The counter clears whenever `REQ` is entered.
- **HOLD:** `inst_valid=1`; `inst` and `inst_pc` are stable. On `inst_valid && inst_ready` the next state is `REQ`; otherwise stay in `HOLD`. No PC write.
- **Redirect** (any state except `FAULT`):
  - Same cycle `pc_we=1`, `pc_src=1`; this overrides any sequential advance.
  - Next state is `REQ` with the counter cleared, and `inst_valid` falls next cycle.
  - If `imem_ready` is high in the same cycle, the returned data is discarded and the buffer is not updated.
  - In `HOLD` with `inst_ready` high in the same cycle, the handshake completes (the instruction counts as consumed) and the redirect applies.
- **FAULT:** `fetch_fault=1`. All other outputs are 0. `redirect` is ignored. Only `sys_rst` exits this state.
- **Handshake rule:** once raised, `imem_req` and `imem_addr` hold until `imem_ready` or `redirect`. The PC is not written during a pending request.
- `pc_we`, `pc_src`, `imem_req` and `imem_addr` are combinational from state and inputs. `inst_valid` and `fetch_fault` decode from state. `inst` and `inst_pc` are registers.

## Timing

- Zero-wait memory: `REQ` → `HOLD` → `REQ`, one instruction per 2 cycles at best. Each wait cycle adds 1 cycle.
- Ready in cycle n gives `inst_valid` high in n+1, and `current_pc` = old+4 in n+1.
- Consume in cycle n gives `imem_req` high in n+1.
- Redirect in cycle n gives `current_pc` = target and `imem_req` at the target in n+1.
- Timeout: with the request raised in cycle n and no ready, `fetch_fault` rises in cycle n+`MAX_WAIT`.
- After reset deassertion in cycle r, the first `imem_req` is in r+1.

## Test plan

- **Sequential fetch:** reset PC 0, memory always ready, `inst_ready=1` → requests at 0, 4, 8, every 2nd cycle. `inst_pc` = 0, 4, 8 with matching `inst`.
- **Memory wait:** 3 wait cycles at PC 0x10 → `imem_req` and `imem_addr=0x10` held 4 cycles; `pc_we` pulses once with ready; `inst_pc=0x10`.
- **Decode backpressure:** `inst_ready=0` for 5 cycles in `HOLD` → `inst` stable, no `imem_req`, no `pc_we`. The first ready cycle is followed by a request at PC+4.
- **Redirect:**
  - Redirect during a wait at 0x20 with target 0x1000, and `imem_ready` high the same cycle → `pc_src=1`, `pc_we=1`, data discarded, next request at 0x1000.
  - Redirect in `HOLD` → `inst_valid` drops the next cycle.
- **Misalignment fault:** redirect to 0x1002 → `imem_req` never asserted, `fetch_fault=1` next cycle. A later redirect is ignored. `sys_rst` clears the fault and restarts from `IDLE`.
- **Timeout:** `MAX_WAIT=8`, memory never ready → `fetch_fault` asserts 8 cycles after the request rises, with `pc_we=0` throughout.
